// File: rtl/debug_trace_pkg.sv
// Shared types and helpers for the writeback-trace serializer.
package debug_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

    localparam logic [31:0] DEFAULT_END_PC = 32'hbfc00100;

    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// Multi-push, single-pop FIFO of trace records; a push group is accepted whole or not at all.
module debug_trace_fifo
    import debug_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LANES = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1,
    localparam int unsigned KW = $clog2(LANES + 1)
) (
    input  logic                   cpu_clk,
    input  logic                   resetn,
    input  logic [KW-1:0]          i_push_n,
    input  trace_rec_t [LANES-1:0] i_push_data,
    input  logic                   i_pop,
    output logic                   o_push_ok,
    output logic                   o_valid,
    output trace_rec_t             o_head,
    output logic [CW-1:0]          o_count
);

    trace_rec_t    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [KW-1:0] w_push_cnt;

    assign o_valid    = (r_count != '0);
    assign w_pop      = i_pop && o_valid;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
    assign o_push_ok  = (CW'(i_push_n) <= w_free);
    assign w_push_cnt = o_push_ok ? i_push_n : '0;

    always_ff @(posedge cpu_clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push_cnt);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop);
        end
    end

    always_ff @(posedge cpu_clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (o_push_ok && (KW'(i) < i_push_n)) begin
                r_mem[r_wptr + PW'(i)] <= i_push_data[i];
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/debug_wb_serializer.sv
// Captures per-lane writeback records, compacts them into program order and
// streams them out one per handshake with a running sequence number.
module debug_wb_serializer
    import debug_trace_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] END_PC      = DEFAULT_END_PC,
    parameter bit          FILTER_ZERO = 1'b1,
    localparam int unsigned LW = lane_idx_w(LANES),
    localparam int unsigned KW = $clog2(LANES + 1),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic                    cpu_clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [LANES-1:0][3:0]   lane_wen,
    input  logic [LANES-1:0][31:0]  lane_pc,
    input  logic [LANES-1:0][4:0]   lane_wnum,
    input  logic [LANES-1:0][31:0]  lane_wdata,
    input  logic [LW-1:0]           first_lane,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [4:0]              out_wnum,
    output logic [31:0]             out_wdata,
    output logic [31:0]             out_seq,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    output logic                    test_end
);

    logic [LANES-1:0]        r_s1_vld;
    logic [LW-1:0]           r_s1_first;
    logic [LANES-1:0][3:0]   r_s1_wen;
    logic [LANES-1:0][31:0]  r_s1_pc;
    logic [LANES-1:0][4:0]   r_s1_wnum;
    logic [LANES-1:0][31:0]  r_s1_wdata;
    logic                    r_overflow;
    logic                    r_test_end;
    logic [31:0]             r_seq;

    logic [LANES-1:0]        w_is_rec;
    logic                    w_end_hit;
    trace_rec_t [LANES-1:0]  w_slot;
    logic [KW-1:0]           w_k;
    logic                    w_push_ok;
    logic                    w_fifo_valid;
    trace_rec_t              w_head;
    logic                    w_capture;

    assign w_capture = enable && !r_test_end;

    always_ff @(posedge cpu_clk) begin
        if (!resetn) begin
            r_s1_vld   <= '0;
            r_s1_first <= '0;
        end else if (w_capture) begin
            r_s1_vld   <= '1;
            r_s1_first <= first_lane;
        end else begin
            r_s1_vld   <= '0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (w_capture) begin
            r_s1_wen   <= lane_wen;
            r_s1_pc    <= lane_pc;
            r_s1_wnum  <= lane_wnum;
            r_s1_wdata <= lane_wdata;
        end
    end

    always_comb begin
        w_is_rec  = '0;
        w_end_hit = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_is_rec[i] = r_s1_vld[i] && (|r_s1_wen[i]) &&
                          (!FILTER_ZERO || (r_s1_wnum[i] != '0));
            if (r_s1_vld[i] && (r_s1_pc[i] == END_PC)) begin
                w_end_hit = 1'b1;
            end
        end
    end

    // Walk lanes oldest-first; the running record count is the prefix sum that picks each slot.
    always_comb begin
        int unsigned n;
        int unsigned idx;
        w_slot = '0;
        n      = 0;
        for (int unsigned j = 0; j < LANES; j++) begin
            idx = (32'(r_s1_first) + j) % LANES;
            if (w_is_rec[idx]) begin
                w_slot[n] = '{pc: r_s1_pc[idx], wnum: r_s1_wnum[idx], wdata: r_s1_wdata[idx]};
                n++;
            end
        end
        w_k = KW'(n);
    end

    debug_trace_fifo #(
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) u_fifo (
        .cpu_clk     (cpu_clk),
        .resetn      (resetn),
        .i_push_n    (w_k),
        .i_push_data (w_slot),
        .i_pop       (out_ready),
        .o_push_ok   (w_push_ok),
        .o_valid     (w_fifo_valid),
        .o_head      (w_head),
        .o_count     (count)
    );

    always_ff @(posedge cpu_clk) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
            r_test_end <= 1'b0;
            r_seq      <= '0;
        end else begin
            if ((w_k != '0) && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_end_hit) begin
                r_test_end <= 1'b1;
            end
            if (w_fifo_valid && out_ready) begin
                r_seq <= r_seq + 32'd1;
            end
        end
    end

    assign out_valid = w_fifo_valid;
    assign out_pc    = w_head.pc;
    assign out_wnum  = w_head.wnum;
    assign out_wdata = w_head.wdata;
    assign out_seq   = r_seq;
    assign overflow  = r_overflow;
    assign test_end  = r_test_end;

endmodule

// File: tb/tb_debug_wb_serializer.sv
// Self-checking bench: queue-based reference model for a 2-lane instance plus directed 4-lane ordering/reset checks.
module tb_debug_wb_serializer;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] ENDPC = 32'hbfc00100;

    logic cpu_clk;
    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- 2-lane instance ----------------
    logic              a_resetn, a_enable, a_ready, a_first;
    logic [1:0][3:0]   a_wen;
    logic [1:0][31:0]  a_pc, a_wdata;
    logic [1:0][4:0]   a_wnum;
    logic              a_valid, a_ovf, a_tend;
    logic [31:0]       a_opc, a_owdata, a_seq;
    logic [4:0]        a_ownum, a_count;

    debug_wb_serializer #(
        .LANES       (2),
        .DEPTH       (DEPTH),
        .END_PC      (ENDPC),
        .FILTER_ZERO (1'b1)
    ) u_dut_a (
        .cpu_clk    (cpu_clk),
        .resetn     (a_resetn),
        .enable     (a_enable),
        .lane_wen   (a_wen),
        .lane_pc    (a_pc),
        .lane_wnum  (a_wnum),
        .lane_wdata (a_wdata),
        .first_lane (a_first),
        .out_valid  (a_valid),
        .out_ready  (a_ready),
        .out_pc     (a_opc),
        .out_wnum   (a_ownum),
        .out_wdata  (a_owdata),
        .out_seq    (a_seq),
        .count      (a_count),
        .overflow   (a_ovf),
        .test_end   (a_tend)
    );

    // ---------------- 4-lane instance ----------------
    logic              b_resetn, b_enable, b_ready;
    logic [1:0]        b_first;
    logic [3:0][3:0]   b_wen;
    logic [3:0][31:0]  b_pc, b_wdata;
    logic [3:0][4:0]   b_wnum;
    logic              b_valid, b_ovf, b_tend;
    logic [31:0]       b_opc, b_owdata, b_seq;
    logic [4:0]        b_ownum, b_count;

    debug_wb_serializer #(
        .LANES       (4),
        .DEPTH       (DEPTH),
        .END_PC      (ENDPC),
        .FILTER_ZERO (1'b1)
    ) u_dut_b (
        .cpu_clk    (cpu_clk),
        .resetn     (b_resetn),
        .enable     (b_enable),
        .lane_wen   (b_wen),
        .lane_pc    (b_pc),
        .lane_wnum  (b_wnum),
        .lane_wdata (b_wdata),
        .first_lane (b_first),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_pc     (b_opc),
        .out_wnum   (b_ownum),
        .out_wdata  (b_owdata),
        .out_seq    (b_seq),
        .count      (b_count),
        .overflow   (b_ovf),
        .test_end   (b_tend)
    );

    // ---------------- reference model (2-lane instance) ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    rec_t        m_fifo[$];
    rec_t        m_s1[$];
    bit          m_s1_end;
    bit          m_ovf;
    bit          m_tend;
    int unsigned m_seq;

    always @(posedge cpu_clk) begin
        if (!a_resetn) begin
            m_fifo.delete();
            m_s1.delete();
            m_s1_end = 0;
            m_ovf    = 0;
            m_tend   = 0;
            m_seq    = 0;
        end else begin
            bit          old_tend;
            int unsigned free;
            rec_t        r;
            if (m_fifo.size() != 0 && a_ready) begin
                void'(m_fifo.pop_front());
                m_seq++;
            end
            free = DEPTH - m_fifo.size();
            if (m_s1.size() <= free) begin
                foreach (m_s1[i]) m_fifo.push_back(m_s1[i]);
            end else begin
                m_ovf = 1;
            end
            old_tend = m_tend;
            if (m_s1_end) m_tend = 1;
            m_s1.delete();
            m_s1_end = 0;
            if (a_enable && !old_tend) begin
                for (int j = 0; j < 2; j++) begin
                    int l;
                    l = (int'(a_first) + j) % 2;
                    if (a_pc[l] == ENDPC) m_s1_end = 1;
                    if (a_wen[l] != 4'h0 && a_wnum[l] != 5'd0) begin
                        r.pc = a_pc[l]; r.wnum = a_wnum[l]; r.wdata = a_wdata[l];
                        m_s1.push_back(r);
                    end
                end
            end
        end
    end

    always @(negedge cpu_clk) begin
        chk("m_valid", a_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk("m_pc", a_opc, m_fifo[0].pc);
            chk("m_wnum", a_ownum, m_fifo[0].wnum);
            chk("m_wdata", a_owdata, m_fifo[0].wdata);
        end
        chk("m_seq", a_seq, m_seq);
        chk("m_count", a_count, m_fifo.size());
        chk("m_overflow", a_ovf, m_ovf);
        chk("m_test_end", a_tend, m_tend);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge cpu_clk);
        #2;
    endtask

    task automatic a_idle();
        a_enable = 1'b0;
        a_wen    = '0;
        a_pc     = '0;
        a_wnum   = '0;
        a_wdata  = '0;
    endtask

    task automatic a_lane(input int l, input logic [3:0] wen, input logic [31:0] pc,
                          input logic [4:0] wn, input logic [31:0] wd);
        a_wen[l] = wen; a_pc[l] = pc; a_wnum[l] = wn; a_wdata[l] = wd;
    endtask

    task automatic a_reset();
        a_resetn = 1'b0;
        step();
        a_resetn = 1'b1;
    endtask

    initial begin
        a_resetn = 1'b0; a_ready = 1'b0; a_first = 1'b0; a_idle();
        b_resetn = 1'b0; b_ready = 1'b0; b_first = '0; b_enable = 1'b0;
        b_wen = '0; b_pc = '0; b_wnum = '0; b_wdata = '0;
        step(); step();

        chk("rst_valid", a_valid, 0);
        chk("rst_count", a_count, 0);
        chk("rst_seq", a_seq, 0);
        chk("rst_overflow", a_ovf, 0);
        chk("rst_test_end", a_tend, 0);
        a_resetn = 1'b1;

        // Two lanes, oldest is lane 1
        a_ready = 1'b1; a_enable = 1'b1; a_first = 1'b1;
        a_lane(1, 4'hf, 32'hbfc00000, 5'd8, 32'h11);
        a_lane(0, 4'hf, 32'hbfc00004, 5'd9, 32'h22);
        step(); a_idle();
        chk("t1_latency_valid", a_valid, 0);
        step();
        chk("t1_r0_valid", a_valid, 1);
        chk("t1_r0_pc", a_opc, 32'hbfc00000);
        chk("t1_r0_wnum", a_ownum, 8);
        chk("t1_r0_wdata", a_owdata, 32'h11);
        chk("t1_r0_seq", a_seq, 0);
        step();
        chk("t1_r1_pc", a_opc, 32'hbfc00004);
        chk("t1_r1_wnum", a_ownum, 9);
        chk("t1_r1_wdata", a_owdata, 32'h22);
        chk("t1_r1_seq", a_seq, 1);
        step();
        chk("t1_drained", a_valid, 0);

        // Filtered lanes: wnum==0 and wen==0
        a_enable = 1'b1; a_first = 1'b0;
        a_lane(0, 4'hf, 32'h100, 5'd0, 32'hdead);
        a_lane(1, 4'h0, 32'h104, 5'd5, 32'hbeef);
        step(); a_idle(); step(); step();
        chk("t2_count", a_count, 0);
        chk("t2_valid", a_valid, 0);

        // Fill to DEPTH, then overflow with a ninth group
        a_reset(); a_ready = 1'b0;
        for (int g = 0; g < 9; g++) begin
            a_enable = 1'b1; a_first = 1'(g % 2);
            a_lane(g % 2, 4'hf, 32'h1000 + 8 * g, 5'(1 + g), 32'(g));
            a_lane((g + 1) % 2, 4'hf, 32'h1000 + 8 * g + 4, 5'(1 + g), 32'(g + 100));
            step();
        end
        a_idle(); step(); step();
        chk("t3_count_full", a_count, 16);
        chk("t3_overflow", a_ovf, 1);
        a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_valid", a_valid, 1);
            chk("t3_drain_pc", a_opc, 32'h1000 + 4 * i);
            chk("t3_drain_seq", a_seq, i);
            step();
        end
        chk("t3_empty", a_valid, 0);
        a_ready = 1'b0;

        // count=15, two-record push coincident with a pop
        a_reset(); a_ready = 1'b0;
        for (int g = 0; g < 7; g++) begin
            a_enable = 1'b1; a_first = 1'b0;
            a_lane(0, 4'hf, 32'h2000 + 8 * g, 5'd3, 32'(g));
            a_lane(1, 4'hf, 32'h2004 + 8 * g, 5'd4, 32'(g));
            step();
        end
        a_lane(0, 4'hf, 32'h2100, 5'd3, 32'h1);
        a_lane(1, 4'h0, 32'h2104, 5'd4, 32'h2);
        step(); a_idle(); step(); step();
        chk("t4_count15", a_count, 15);
        a_enable = 1'b1; a_first = 1'b0;
        a_lane(0, 4'hf, 32'h2200, 5'd5, 32'h5);
        a_lane(1, 4'hf, 32'h2204, 5'd6, 32'h6);
        step(); a_idle(); a_ready = 1'b1;
        step(); a_ready = 1'b0;
        chk("t4_count16", a_count, 16);
        chk("t4_no_overflow", a_ovf, 0);

        // END_PC on a non-writing lane
        a_reset(); a_ready = 1'b0;
        a_enable = 1'b1; a_first = 1'b0;
        a_lane(0, 4'hf, 32'h3000, 5'd1, 32'ha);
        a_lane(1, 4'hf, 32'h3004, 5'd2, 32'hb);
        step();
        a_lane(0, 4'h0, ENDPC, 5'd4, 32'hc);
        a_lane(1, 4'hf, 32'h3008, 5'd7, 32'h77);
        step(); a_idle(); step();
        chk("t5_test_end", a_tend, 1);
        for (int g = 0; g < 4; g++) begin
            a_enable = 1'b1;
            a_lane(0, 4'hf, 32'h4000 + 8 * g, 5'd9, 32'(g));
            a_lane(1, 4'hf, 32'h4004 + 8 * g, 5'd9, 32'(g));
            step();
        end
        a_idle(); step(); step();
        chk("t5_count", a_count, 3);
        a_ready = 1'b1;
        chk("t5_pc0", a_opc, 32'h3000); step();
        chk("t5_pc1", a_opc, 32'h3004); step();
        chk("t5_pc2", a_opc, 32'h3008); step();
        chk("t5_empty", a_valid, 0);
        chk("t5_test_end_sticky", a_tend, 1);
        a_ready = 1'b0;

        // Randomized traffic with occasional resets
        a_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_resetn = ($urandom_range(0, 199) != 0);
            a_enable = ($urandom_range(0, 7) != 0);
            a_first  = 1'($urandom_range(0, 1));
            for (int l = 0; l < 2; l++) begin
                logic [31:0] pc;
                pc = $urandom;
                if (pc == ENDPC) pc = pc ^ 32'h1;
                a_lane(l, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), pc,
                       5'($urandom), $urandom);
            end
            a_ready = ((cyc / 256) % 2 == 1) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 2) == 0);
            step();
        end
        a_resetn = 1'b1; a_idle(); a_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // 4 lanes, oldest is lane 3; reset pulse mid-drain
        b_resetn = 1'b1; b_ready = 1'b0; b_enable = 1'b1; b_first = 2'd3;
        for (int l = 0; l < 4; l++) begin
            b_wen[l] = 4'hf; b_pc[l] = 32'h100 + 32'h10 * l;
            b_wnum[l] = 5'(l + 1); b_wdata[l] = 32'(l);
        end
        step();
        for (int l = 0; l < 4; l++) b_pc[l] = 32'h200 + 32'h10 * l;
        step();
        b_enable = 1'b0; b_wen = '0; step(); step();
        chk("b_count8", b_count, 8);
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b_g0_pc", b_opc, 32'h100 + 32'h10 * ((3 + i) % 4));
            chk("b_g0_wnum", b_ownum, 5'(((3 + i) % 4) + 1));
            chk("b_g0_seq", b_seq, i);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("b_g1_pc", b_opc, 32'h200 + 32'h10 * ((3 + i) % 4));
            chk("b_g1_seq", b_seq, 4 + i);
            step();
        end
        b_resetn = 1'b0; step();
        chk("b_rst_valid", b_valid, 0);
        chk("b_rst_count", b_count, 0);
        chk("b_rst_seq", b_seq, 0);
        b_resetn = 1'b1; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_wb_serializer.md
# debug_wb_serializer

Synthesizable N-lane writeback-trace serializer for multi-issue CPU cores. It captures per-lane debug writeback records each cycle, orders them into program order using the oldest-lane index, filters non-writes, and buffers them in a multi-push FIFO. The FIFO drains as a single valid/ready record stream for an on-chip trace checker or UART dumper. It sits beside the CPU core inside the SoC top and replaces bench-side lane reordering.

## Interface
Parameters:
- LANES, 2, number of writeback lanes (1..4)
- DEPTH, 16, FIFO entries; power of two, >= 2*LANES
- END_PC, 32'hbfc00100, PC that marks end of test
- FILTER_ZERO, 1, when 1 drop records with wnum==0

Ports:
- cpu_clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low (clock cpu_clk)
- enable  in  1  capture enable; when 0, lanes are ignored
- lane_wen  in  LANES x 4  per-lane byte write enables
- lane_pc  in  LANES x 32  per-lane PC
- lane_wnum  in  LANES x 5  per-lane destination register
- lane_wdata  in  LANES x 32  per-lane write data
- first_lane  in  max(1,$clog2(LANES))  index of oldest lane this cycle
- out_valid  out  1  head record valid
- out_ready  in  1  consumer accepts head
- out_pc / out_wnum / out_wdata  out  32/5/32  head record
- out_seq  out  32  sequence number of head record
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a group was dropped
- test_end  out  1  sticky: END_PC retired

## Operation
- Stage 1 (S1) registers all lane inputs and first_lane when enable && !test_end; otherwise S1 lane valids clear.
- Lane i in S1 is a record iff |wen and (!FILTER_ZERO or wnum!=0).
- Program order: first_lane, first_lane+1, … modulo LANES. Records are compacted into k consecutive slots (k = 0..LANES), oldest first.
- Push: if k <= free, where free = DEPTH - count + (pop this cycle ? 1 : 0), write all k at wptr..wptr+k-1 (mod DEPTH). Otherwise write none and set overflow. The group is never split.
- Pop: out_valid && out_ready advances rptr by 1; out_seq increments by 1 and wraps at 2^32. Records are numbered 0,1,2,… in acceptance order.
- test_end is set when any S1 lane has pc==END_PC, independent of wen. The same group is still pushed under the normal rules. S1 captures nothing afterwards. The FIFO keeps draining.
- overflow and test_end clear only on reset.

## Timing
- Reset: out_valid=0, count=0, out_seq=0, overflow=0, test_end=0, and all pointers and S1 valids are 0. Payload outputs are don't-care while out_valid=0.
- Latency: lane inputs sampled at edge t enter S1. The FIFO write happens at edge t+1, and out_valid goes high after edge t+1 if the FIFO was empty.
- No combinational path from lane inputs or out_ready to out_valid.
- out_* remain stable while out_valid && !out_ready.
- Simultaneous push+pop in the same cycle is legal at full: count_next = count + k - pop.
- Reset asserted mid-operation discards all buffered records on the next edge.

## Structure
- Package debug_trace_pkg:
  - trace_rec_t packed struct {pc[31:0], wnum[4:0], wdata[31:0]}
  - default END_PC constant
  - lane-index width function
- Sub-module debug_trace_fifo: DEPTH-entry, up-to-LANES-push, single-pop synchronous FIFO of trace_rec_t, with ptr-width+1 occupancy.
- Compaction (rotate by first_lane, then prefix-sum of valid bits) lives in the top module.

## Test plan
- LANES=2, first_lane=1, lane1 {pc 0xbfc00000, r8, 0x11}, lane0 {pc 0xbfc00004, r9, 0x22}, out_ready=1 -> out emits pc 0xbfc00000 then 0xbfc00004, with out_seq 0 then 1, first record 2 cycles after input.
- Lane with wen=4'hf, wnum=0 (FILTER_ZERO=1), and lane with wen=0 -> nothing pushed; count stays 0.
- DEPTH=16, out_ready=0, 8 cycles of 2 records -> count=16. A 9th group of 2 -> overflow=1, count stays 16. Raising out_ready returns records with seq 0..15 in order.
- count=15, same-cycle 2-record push plus pop -> no overflow, count=16.
- Lane0 pc=END_PC with wen=0 -> test_end=1 next edge. Later lane writes are ignored, and the FIFO still drains the earlier records.
- LANES=4, first_lane=3, all lanes valid -> output order is lane 3,0,1,2; a resetn pulse mid-drain -> out_valid=0, count=0, out_seq=0.
